// File: rtl/conv_sequencer_if.sv
// Bus between the FIR convolution sequencer and its neighbours: sample FIFO,
// history RAM, coefficient ROM, external MAC and frame assembler.
interface conv_sequencer_if #(
   parameter int NUM_TAPS = 32,
   parameter int SAMPLE_W = 24,
   parameter int ACC_W    = 45
);
   localparam int TAP_W = $clog2(NUM_TAPS);

   logic                in_valid;
   logic [SAMPLE_W-1:0] in_sample;
   logic                in_chan;
   logic                in_ready;
   logic                smp_we;
   logic [TAP_W:0]      smp_waddr;
   logic [SAMPLE_W-1:0] smp_wdata;
   logic [TAP_W:0]      smp_raddr;
   logic [TAP_W-1:0]    coef_raddr;
   logic                mac_clr;
   logic                mac_en;
   logic [ACC_W-1:0]    mac_acc;
   logic                out_valid;
   logic [SAMPLE_W-1:0] out_sample;
   logic                out_chan;
   logic                out_ready;
   logic                busy;

   modport master (
      input  in_valid, in_sample, in_chan, mac_acc, out_ready,
      output in_ready, smp_we, smp_waddr, smp_wdata, smp_raddr, coef_raddr,
             mac_clr, mac_en, out_valid, out_sample, out_chan, busy
   );

   modport slave (
      output in_valid, in_sample, in_chan, mac_acc, out_ready,
      input  in_ready, smp_we, smp_waddr, smp_wdata, smp_raddr, coef_raddr,
             mac_clr, mac_en, out_valid, out_sample, out_chan, busy
   );
endinterface

// File: rtl/conv_sequencer.sv
// Stereo FIR convolution sequencer: clears the history RAM, stores each sample,
// walks NUM_TAPS RAM/ROM reads into a shared MAC and emits a saturated result.
module conv_sequencer #(
   parameter int NUM_TAPS = 32,
   parameter int SAMPLE_W = 24,
   parameter int COEF_W   = 16,
   parameter int ACC_W    = 45
) (
   input  logic             clk,
   input  logic             rst_n,
   conv_sequencer_if.master bus
);
   localparam int TAP_W = $clog2(NUM_TAPS);
   localparam int CLR_W = TAP_W + 2;

   typedef enum logic [2:0] {
      ST_CLEAR  = 3'd0,
      ST_IDLE   = 3'd1,
      ST_WRITE  = 3'd2,
      ST_ISSUE  = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_RESULT = 3'd5
   } state_t;

   // Q1.x rescale, then clamp when the discarded upper bits disagree with the sign.
   function automatic logic [SAMPLE_W-1:0] saturate(input logic [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] shifted;
      logic [ACC_W-SAMPLE_W:0] upper;
      shifted = $signed(acc) >>> (COEF_W - 1);
      upper   = shifted[ACC_W-1:SAMPLE_W-1];
      if ((&upper) || !(|upper)) begin
         saturate = shifted[SAMPLE_W-1:0];
      end else if (upper[ACC_W-SAMPLE_W]) begin
         saturate = {1'b1, {(SAMPLE_W-1){1'b0}}};
      end else begin
         saturate = {1'b0, {(SAMPLE_W-1){1'b1}}};
      end
   endfunction

   state_t              state_r, state_s;
   logic [CLR_W-1:0]    clr_cnt_r, clr_cnt_s;
   logic [TAP_W-1:0]    k_r, k_s, k_nxt_s;
   logic                drain_r, drain_s;
   logic                chan_r, chan_s;
   logic [TAP_W-1:0]    head_r [2];
   logic [TAP_W-1:0]    head_s [2];
   logic [TAP_W-1:0]    head_sel_s;

   logic                in_ready_r, in_ready_s;
   logic                smp_we_r, smp_we_s;
   logic [TAP_W:0]      smp_waddr_r, smp_waddr_s;
   logic [SAMPLE_W-1:0] smp_wdata_r, smp_wdata_s;
   logic [TAP_W:0]      smp_raddr_r, smp_raddr_s;
   logic [TAP_W-1:0]    coef_raddr_r, coef_raddr_s;
   logic                mac_clr_r, mac_clr_s;
   logic                mac_en_r, mac_en_s;
   logic                out_valid_r, out_valid_s;
   logic [SAMPLE_W-1:0] out_sample_r, out_sample_s;
   logic                out_chan_r, out_chan_s;
   logic                busy_r, busy_s;

   // Next-state and next-output logic; every output is registered from here.
   always_comb begin
      state_s      = state_r;
      clr_cnt_s    = clr_cnt_r;
      k_s          = k_r;
      drain_s      = drain_r;
      chan_s       = chan_r;
      head_s       = head_r;
      head_sel_s   = head_r[chan_r];
      k_nxt_s      = k_r + TAP_W'(1);
      smp_we_s     = 1'b0;
      smp_waddr_s  = smp_waddr_r;
      smp_wdata_s  = smp_wdata_r;
      smp_raddr_s  = smp_raddr_r;
      coef_raddr_s = coef_raddr_r;
      mac_clr_s    = 1'b0;
      mac_en_s     = (state_r == ST_ISSUE);
      out_valid_s  = out_valid_r;
      out_sample_s = out_sample_r;
      out_chan_s   = out_chan_r;

      case (state_r)
         ST_CLEAR: begin
            if (clr_cnt_r == CLR_W'(2 * NUM_TAPS)) begin
               state_s = ST_IDLE;
            end else begin
               smp_we_s    = 1'b1;
               smp_waddr_s = clr_cnt_r[TAP_W:0];
               smp_wdata_s = {SAMPLE_W{1'b0}};
               clr_cnt_s   = clr_cnt_r + CLR_W'(1);
            end
         end
         ST_IDLE: begin
            if (bus.in_valid && in_ready_r) begin
               state_s     = ST_WRITE;
               chan_s      = bus.in_chan;
               smp_we_s    = 1'b1;
               smp_waddr_s = {bus.in_chan, head_r[bus.in_chan]};
               smp_wdata_s = bus.in_sample;
               mac_clr_s   = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            state_s      = ST_ISSUE;
            k_s          = {TAP_W{1'b0}};
            smp_raddr_s  = {chan_r, head_sel_s};
            coef_raddr_s = {TAP_W{1'b0}};
         end
         ST_ISSUE: begin
            // Tap k reads the sample k positions behind the newest one.
            if (k_r == TAP_W'(NUM_TAPS - 1)) begin
               state_s = ST_DRAIN;
               drain_s = 1'b0;
            end else begin
               k_s          = k_nxt_s;
               smp_raddr_s  = {chan_r, head_sel_s - k_nxt_s};
               coef_raddr_s = k_nxt_s;
            end
         end
         ST_DRAIN: begin
            if (drain_r) begin
               state_s        = ST_RESULT;
               out_valid_s    = 1'b1;
               out_sample_s   = saturate(bus.mac_acc);
               out_chan_s     = chan_r;
               head_s[chan_r] = head_sel_s + TAP_W'(1);
            end else begin
               drain_s = 1'b1;
            end
         end
         ST_RESULT: begin
            if (bus.out_ready) begin
               state_s     = ST_IDLE;
               out_valid_s = 1'b0;
            end else begin
               state_s = ST_RESULT;
            end
         end
         default: begin
            state_s = ST_CLEAR;
         end
      endcase

      in_ready_s = (state_s == ST_IDLE);
      busy_s     = (state_s != ST_IDLE);
   end

   // State, pointers and registered outputs; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_CLEAR;
         clr_cnt_r    <= {CLR_W{1'b0}};
         k_r          <= {TAP_W{1'b0}};
         drain_r      <= 1'b0;
         chan_r       <= 1'b0;
         head_r[0]    <= {TAP_W{1'b0}};
         head_r[1]    <= {TAP_W{1'b0}};
         in_ready_r   <= 1'b0;
         smp_we_r     <= 1'b0;
         smp_waddr_r  <= {(TAP_W+1){1'b0}};
         smp_wdata_r  <= {SAMPLE_W{1'b0}};
         smp_raddr_r  <= {(TAP_W+1){1'b0}};
         coef_raddr_r <= {TAP_W{1'b0}};
         mac_clr_r    <= 1'b0;
         mac_en_r     <= 1'b0;
         out_valid_r  <= 1'b0;
         out_sample_r <= {SAMPLE_W{1'b0}};
         out_chan_r   <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         clr_cnt_r    <= clr_cnt_s;
         k_r          <= k_s;
         drain_r      <= drain_s;
         chan_r       <= chan_s;
         head_r[0]    <= head_s[0];
         head_r[1]    <= head_s[1];
         in_ready_r   <= in_ready_s;
         smp_we_r     <= smp_we_s;
         smp_waddr_r  <= smp_waddr_s;
         smp_wdata_r  <= smp_wdata_s;
         smp_raddr_r  <= smp_raddr_s;
         coef_raddr_r <= coef_raddr_s;
         mac_clr_r    <= mac_clr_s;
         mac_en_r     <= mac_en_s;
         out_valid_r  <= out_valid_s;
         out_sample_r <= out_sample_s;
         out_chan_r   <= out_chan_s;
         busy_r       <= busy_s;
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.smp_we     = smp_we_r;
   assign bus.smp_waddr  = smp_waddr_r;
   assign bus.smp_wdata  = smp_wdata_r;
   assign bus.smp_raddr  = smp_raddr_r;
   assign bus.coef_raddr = coef_raddr_r;
   assign bus.mac_clr    = mac_clr_r;
   assign bus.mac_en     = mac_en_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_sample = out_sample_r;
   assign bus.out_chan   = out_chan_r;
   assign bus.busy       = busy_r;
endmodule

// File: tb/tb_conv_sequencer.sv
// Table-driven bench for conv_sequencer with behavioural sample RAM, coefficient
// ROM and MAC around it; expected outputs are hand-computed per vector.
module tb_conv_sequencer;
   localparam int NUM_TAPS = 32;
   localparam int SAMPLE_W = 24;
   localparam int COEF_W   = 16;
   localparam int ACC_W    = 45;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_sequencer_if #(.NUM_TAPS(NUM_TAPS), .SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) bus ();

   conv_sequencer #(
      .NUM_TAPS(NUM_TAPS), .SAMPLE_W(SAMPLE_W), .COEF_W(COEF_W), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   logic [SAMPLE_W-1:0]     ram [2*NUM_TAPS];
   logic [COEF_W-1:0]       rom [NUM_TAPS];
   logic signed [SAMPLE_W-1:0] ram_q;
   logic signed [COEF_W-1:0]   rom_q;
   logic signed [ACC_W-1:0]    acc, prod;

   assign prod        = ram_q * rom_q;
   assign bus.mac_acc = acc;

   // RAM/ROM with one-cycle read latency and the external accumulator.
   always @(posedge clk) begin
      if (bus.smp_we) ram[bus.smp_waddr] <= bus.smp_wdata;
      ram_q <= ram[bus.smp_raddr];
      rom_q <= rom[bus.coef_raddr];
      if (bus.mac_clr) acc <= '0;
      else if (bus.mac_en) acc <= acc + prod;
   end

   typedef struct {
      bit                  rst;
      bit                  cset;
      bit                  chan;
      logic [SAMPLE_W-1:0] smp;
      logic [SAMPLE_W-1:0] exp_out;
      logic [5:0]          exp_waddr;
      int                  hold;
   } vec_t;

   vec_t vecs[$];
   int n_chk  = 0;
   int n_pass = 0;

   function automatic void add(bit rst, bit cset, bit chan, logic [23:0] smp,
                               logic [23:0] exp_out, logic [5:0] waddr, int hold);
      vec_t v;
      v.rst = rst; v.cset = cset; v.chan = chan; v.smp = smp;
      v.exp_out = exp_out; v.exp_waddr = waddr; v.hold = hold;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_coefs(input bit cset);
      for (int k = 0; k < NUM_TAPS; k++) rom[k] = cset ? 16'h7FFF : COEF_W'(k + 1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctrl"}, {bus.in_ready, bus.smp_we, bus.mac_clr, bus.mac_en,
                           bus.out_valid, bus.out_chan, bus.busy}, 64'd0);
      chk({tag, "_addr"}, {bus.smp_waddr, bus.smp_raddr, bus.coef_raddr}, 64'd0);
      chk({tag, "_data"}, {bus.smp_wdata, bus.out_sample}, 64'd0);
   endtask

   // Hold reset for two edges, release, then watch the whole CLEAR sweep.
   task automatic hold_reset();
      int we_cnt;
      int err;
      int n;
      rst_n = 1'b0;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      cyc();
      cyc();
      check_zero("reset");
      rst_n = 1'b1;
      we_cnt = 0; err = 0; n = 0;
      while (n < 200) begin
         cyc();
         n++;
         if (bus.in_ready) break;
         if (bus.smp_we) begin
            if (bus.smp_waddr !== 6'(we_cnt) || bus.smp_wdata !== 24'd0) err++;
            we_cnt++;
         end
         if (bus.out_valid || bus.mac_en || bus.mac_clr) err++;
      end
      bus.in_valid = 1'b0;
      chk("clear_we_cycles", we_cnt, 64'd64);
      chk("clear_seq_errors", err, 64'd0);
      chk("clear_in_ready", bus.in_ready, 64'd1);
      chk("idle_we", bus.smp_we, 64'd0);
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      int mac_cnt;
      int rdy_err;
      int unstable;
      logic [SAMPLE_W-1:0] held_s;
      logic held_c;
      set_coefs(v.cset);
      n = 0;
      while (!bus.in_ready && n < 100) begin
         cyc();
         n++;
      end
      chk("accept_ready", bus.in_ready, 64'd1);
      bus.in_valid  = 1'b1;
      bus.in_sample = v.smp;
      bus.in_chan   = v.chan;
      bus.out_ready = (v.hold == 0);
      cyc();
      // in_valid stays high with different data while busy; it must be ignored
      bus.in_sample = ~v.smp;
      bus.in_chan   = ~v.chan;
      chk("write_ctrl", {bus.smp_we, bus.mac_clr, bus.in_ready, bus.busy}, 64'b1101);
      chk("write_addr", bus.smp_waddr, v.exp_waddr);
      chk("write_data", bus.smp_wdata, v.smp);
      n = 1; mac_cnt = 0; rdy_err = 0;
      while (!bus.out_valid && n < 100) begin
         if (bus.mac_en) mac_cnt++;
         if (bus.in_ready) rdy_err++;
         cyc();
         n++;
      end
      bus.in_valid = 1'b0;
      chk("latency", n, 64'd36);
      chk("mac_en_cycles", mac_cnt, 64'd32);
      chk("busy_in_ready", rdy_err, 64'd0);
      chk("out_sample", bus.out_sample, v.exp_out);
      chk("out_chan", bus.out_chan, v.chan);
      held_s = bus.out_sample; held_c = bus.out_chan; unstable = 0;
      for (int i = 0; i < v.hold; i++) begin
         cyc();
         if (!bus.out_valid || bus.out_sample !== held_s || bus.out_chan !== held_c
             || bus.in_ready) unstable++;
      end
      if (v.hold > 0) chk("hold_stable", unstable, 64'd0);
      bus.out_ready = 1'b1;
      cyc();
      chk("post_handshake", {bus.out_valid, bus.in_ready}, 64'b01);
   endtask

   initial begin
      int n;
      bus.in_valid = 1'b0; bus.in_sample = 24'd0; bus.in_chan = 1'b0; bus.out_ready = 1'b1;
      set_coefs(1'b0);

      // impulse on left, h[k]=k+1
      add(1'b1, 1'b0, 1'b0, 24'd32768, 24'd1, 6'd0, 0);
      add(1'b0, 1'b0, 1'b0, 24'd0,     24'd2, 6'd1, 0);
      add(1'b0, 1'b0, 1'b0, 24'd0,     24'd3, 6'd2, 0);
      add(1'b0, 1'b0, 1'b0, 24'd0,     24'd4, 6'd3, 0);
      // channel independence; the fifth L result is held off for 10 cycles
      add(1'b1, 1'b0, 1'b0, 24'd32768, 24'd1,  6'd0,  0);
      add(1'b0, 1'b0, 1'b1, 24'd0,     24'd0,  6'd32, 0);
      add(1'b0, 1'b0, 1'b0, 24'd32768, 24'd3,  6'd1,  0);
      add(1'b0, 1'b0, 1'b1, 24'd0,     24'd0,  6'd33, 0);
      add(1'b0, 1'b0, 1'b0, 24'd32768, 24'd6,  6'd2,  0);
      add(1'b0, 1'b0, 1'b1, 24'd0,     24'd0,  6'd34, 0);
      add(1'b0, 1'b0, 1'b0, 24'd32768, 24'd10, 6'd3,  0);
      add(1'b0, 1'b0, 1'b1, 24'd0,     24'd0,  6'd35, 0);
      add(1'b0, 1'b0, 1'b0, 24'd32768, 24'd15, 6'd4,  10);
      add(1'b0, 1'b0, 1'b1, 24'd0,     24'd0,  6'd36, 0);
      // full-length impulse then wrap of the left head pointer
      for (int i = 0; i < 32; i++)
         add(i == 0, 1'b0, 1'b0, (i == 0) ? 24'd32768 : 24'd0, 24'(i + 1), 6'(i), 0);
      add(1'b0, 1'b0, 1'b0, 24'd32768, 24'd1, 6'd0, 0);
      add(1'b0, 1'b0, 1'b0, 24'd0,     24'd2, 6'd1, 0);
      // saturation, positive then negative
      for (int i = 0; i < 33; i++)
         add(i == 0, 1'b1, 1'b0, 24'h7FFFFF, (i == 0) ? 24'h7FFEFF : 24'h7FFFFF, 6'(i % 32), 0);
      add(1'b1, 1'b1, 1'b0, 24'h800000, 24'h800100, 6'd0, 0);
      add(1'b0, 1'b1, 1'b0, 24'h800000, 24'h800000, 6'd1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) hold_reset();
         run_vec(vecs[i]);
      end

      // reset in the tenth ISSUE cycle: result dropped, CLEAR reruns, heads back to 0
      set_coefs(1'b0);
      n = 0;
      while (!bus.in_ready && n < 100) begin
         cyc();
         n++;
      end
      chk("midrst_ready", bus.in_ready, 64'd1);
      bus.in_valid = 1'b1; bus.in_sample = 24'd32768; bus.in_chan = 1'b0;
      cyc();
      bus.in_valid = 1'b0;
      repeat (10) cyc();
      chk("midrst_in_issue", {bus.mac_en, bus.busy}, 64'b11);
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      hold_reset();
      add(1'b0, 1'b0, 1'b0, 24'd32768, 24'd1, 6'd0, 0);
      run_vec(vecs[vecs.size() - 1]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
